// File: rtl/debounce_switch.sv
// Switch debouncer: synchronises a raw switch level and accepts a new level only after
// it has been stable for DEBOUNCE_LIMIT clocks. Registered one-cycle rise/fall pulses.
module debounce_switch #(
    parameter int DEBOUNCE_LIMIT = 250000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic i_Clk,
    input  logic i_reset_n,
    input  logic i_Switch,
    output logic o_Switch,
    output logic o_Rise,
    output logic o_Fall
);

    localparam int CNT_W = $clog2(DEBOUNCE_LIMIT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_LIMIT - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   s_sync;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   switch_q, switch_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], i_Switch};
    assign s_sync = sync_q[SYNC_STAGES-1];

    // The count only runs while the synchronised level disagrees with the accepted one,
    // so any sample that agrees again throws the partial count away.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        cnt_d    = '0;
        switch_d = switch_q;
        rise_d   = 1'b0;
        fall_d   = 1'b0;
        if (s_sync != switch_q) begin
            if (cnt_q == CNT_LAST) begin
                switch_d = s_sync;
                rise_d   = s_sync;
                fall_d   = ~s_sync;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_reset_n) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (!i_reset_n) begin
            sync_q   <= '0;
            cnt_q    <= '0;
            switch_q <= 1'b0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            cnt_q    <= cnt_d;
            switch_q <= switch_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
        end
    end

    assign o_Switch = switch_q;
    assign o_Rise   = rise_q;
    assign o_Fall   = fall_q;

endmodule

// File: tb/tb_debounce_switch.sv
// Self-checking bench for debounce_switch (DEBOUNCE_LIMIT=8, SYNC_STAGES=2): directed
// scenarios plus random runs compared against a sample-history reference model.
module tb_debounce_switch;

    localparam int LIMIT = 8;
    localparam int SYNC  = 2;
    localparam int HIST  = SYNC + LIMIT;
    localparam int LAT   = SYNC + LIMIT;

    logic i_Clk;
    logic i_reset_n;
    logic i_Switch;
    logic o_Switch;
    logic o_Rise;
    logic o_Fall;

    int n_cmp;
    int n_err;

    debounce_switch #(
        .DEBOUNCE_LIMIT(LIMIT),
        .SYNC_STAGES   (SYNC)
    ) dut (
        .i_Clk    (i_Clk),
        .i_reset_n(i_reset_n),
        .i_Switch (i_Switch),
        .o_Switch (o_Switch),
        .o_Rise   (o_Rise),
        .o_Fall   (o_Fall)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    // Reference model: remembers the raw level seen at each rising edge. The level used at
    // edge n is the one sampled SYNC edges earlier; the output flips when the last LIMIT
    // such levels all disagree with it.
    logic hist [HIST];
    logic m_sw, m_rise, m_fall, m_all_diff;

    always @(posedge i_Clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            for (int i = 0; i < HIST; i++) hist[i] = 1'b0;
            m_sw   = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
        end else begin
            m_all_diff = 1'b1;
            for (int j = SYNC - 1; j <= SYNC + LIMIT - 2; j++)
                if (hist[j] == m_sw) m_all_diff = 1'b0;
            m_rise = 1'b0;
            m_fall = 1'b0;
            if (m_all_diff) begin
                m_sw   = ~m_sw;
                m_rise = m_sw;
                m_fall = ~m_sw;
            end
            for (int i = HIST - 1; i > 0; i--) hist[i] = hist[i-1];
            hist[0] = i_Switch;
        end
    end

    // Drive a level on the current falling edge and advance to the next falling edge.
    task automatic step(input logic v);
        i_Switch = v;
        @(negedge i_Clk);
    endtask

    task automatic test_reset();
        i_Switch  = 1'b1;
        i_reset_n = 1'b1;
        #1 i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
            n_err++;
            $display("FAIL reset_async: got sw/rise/fall=%b%b%b required 000", o_Switch, o_Rise, o_Fall);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge i_Clk);
            n_cmp++;
            if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
                n_err++;
                $display("FAIL reset_hold cyc %0d: got sw/rise/fall=%b%b%b required 000", c, o_Switch, o_Rise, o_Fall);
            end
        end
        i_Switch  = 1'b0;
        i_reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            step(1'b0);
            n_cmp++;
            if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
                n_err++;
                $display("FAIL reset_release cyc %0d: got sw/rise/fall=%b%b%b required 000", c, o_Switch, o_Rise, o_Fall);
            end
        end
    endtask

    task automatic test_clean_press();
        bit found = 1'b0;
        for (int c = 1; c <= 3 * LAT && !found; c++) begin
            step(1'b1);
            n_cmp++;
            if (o_Switch !== m_sw || o_Rise !== m_rise || o_Fall !== m_fall) begin
                n_err++;
                $display("FAIL press_model cyc %0d: got %b%b%b required %b%b%b", c, o_Switch, o_Rise, o_Fall, m_sw, m_rise, m_fall);
            end
            if (o_Switch === 1'b1) begin
                found = 1'b1;
                n_cmp++;
                if (c != LAT || o_Rise !== 1'b1) begin
                    n_err++;
                    $display("FAIL press_latency: got %0d clocks rise=%b required %0d clocks rise=1", c, o_Rise, LAT);
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL press_timeout: o_Switch=%b after %0d clocks required 1", o_Switch, 3 * LAT);
        end
        step(1'b1);
        n_cmp++;
        if (o_Switch !== 1'b1 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
            n_err++;
            $display("FAIL press_pulse_width: got sw/rise/fall=%b%b%b required 100", o_Switch, o_Rise, o_Fall);
        end
    endtask

    task automatic test_release();
        bit found = 1'b0;
        for (int c = 1; c <= 3 * LAT && !found; c++) begin
            step(1'b0);
            n_cmp++;
            if (o_Switch !== m_sw || o_Rise !== m_rise || o_Fall !== m_fall) begin
                n_err++;
                $display("FAIL release_model cyc %0d: got %b%b%b required %b%b%b", c, o_Switch, o_Rise, o_Fall, m_sw, m_rise, m_fall);
            end
            if (o_Switch === 1'b0) begin
                found = 1'b1;
                n_cmp++;
                if (c != LAT || o_Fall !== 1'b1) begin
                    n_err++;
                    $display("FAIL release_latency: got %0d clocks fall=%b required %0d clocks fall=1", c, o_Fall, LAT);
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL release_timeout: o_Switch=%b after %0d clocks required 0", o_Switch, 3 * LAT);
        end
        step(1'b0);
        n_cmp++;
        if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
            n_err++;
            $display("FAIL release_pulse_width: got sw/rise/fall=%b%b%b required 000", o_Switch, o_Rise, o_Fall);
        end
    endtask

    task automatic test_bounce();
        logic pat [];
        pat = new[7 + 1 + 7 + 2 * LAT];
        foreach (pat[i]) pat[i] = (i < 7 || (i >= 8 && i < 15)) ? 1'b1 : 1'b0;
        foreach (pat[i]) begin
            step(pat[i]);
            n_cmp++;
            if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0 ||
                m_sw !== 1'b0 || m_rise !== 1'b0) begin
                n_err++;
                $display("FAIL bounce cyc %0d: got sw/rise/fall=%b%b%b required 000 (model %b)", i, o_Switch, o_Rise, o_Fall, m_sw);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit found = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1);
            n_cmp++;
            if (o_Switch !== 1'b0 || o_Rise !== 1'b0) begin
                n_err++;
                $display("FAIL midreset_pre cyc %0d: got sw/rise=%b%b required 00", c, o_Switch, o_Rise);
            end
        end
        #2 i_reset_n = 1'b0;
        #1;
        n_cmp++;
        if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_assert: got sw/rise/fall=%b%b%b required 000", o_Switch, o_Rise, o_Fall);
        end
        @(negedge i_Clk);
        i_reset_n = 1'b1;
        for (int c = 1; c <= 3 * LAT && !found; c++) begin
            step(1'b1);
            n_cmp++;
            if (o_Switch !== m_sw || o_Rise !== m_rise || o_Fall !== m_fall) begin
                n_err++;
                $display("FAIL midreset_model cyc %0d: got %b%b%b required %b%b%b", c, o_Switch, o_Rise, o_Fall, m_sw, m_rise, m_fall);
            end
            if (o_Switch === 1'b1) begin
                found = 1'b1;
                n_cmp++;
                if (c != LAT) begin
                    n_err++;
                    $display("FAIL midreset_latency: got %0d clocks required %0d", c, LAT);
                end
            end
        end
        n_cmp++;
        if (!found) begin
            n_err++;
            $display("FAIL midreset_timeout: o_Switch=%b required 1", o_Switch);
        end
    endtask

    task automatic test_toggle_storm(input logic start_level);
        logic v = start_level;
        for (int c = 0; c < 100; c++) begin
            v = ~v;
            step(v);
            n_cmp++;
            if (o_Switch !== start_level || o_Rise !== 1'b0 || o_Fall !== 1'b0 || m_sw !== start_level) begin
                n_err++;
                $display("FAIL toggle_storm cyc %0d: got sw/rise/fall=%b%b%b required %b00", c, o_Switch, o_Rise, o_Fall, start_level);
            end
        end
    endtask

    task automatic test_random();
        int   cyc = 0;
        logic lvl;
        while (cyc < 2000) begin
            if ($urandom_range(0, 39) == 0) begin
                i_reset_n = 1'b0;
                #1;
                n_cmp++;
                if (o_Switch !== 1'b0 || o_Rise !== 1'b0 || o_Fall !== 1'b0) begin
                    n_err++;
                    $display("FAIL random_reset cyc %0d: got sw/rise/fall=%b%b%b required 000", cyc, o_Switch, o_Rise, o_Fall);
                end
                @(negedge i_Clk);
                i_reset_n = 1'b1;
            end
            lvl = 1'($urandom_range(0, 1));
            for (int k = $urandom_range(1, 12); k > 0; k--) begin
                step(lvl);
                cyc++;
                n_cmp++;
                if (o_Switch !== m_sw || o_Rise !== m_rise || o_Fall !== m_fall ||
                    (o_Rise === 1'b1 && o_Fall === 1'b1)) begin
                    n_err++;
                    $display("FAIL random cyc %0d: got sw/rise/fall=%b%b%b required %b%b%b", cyc, o_Switch, o_Rise, o_Fall, m_sw, m_rise, m_fall);
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_clean_press();
        test_release();
        for (int c = 0; c < 2 * LAT; c++) step(1'b0);
        test_bounce();
        test_reset_mid();
        test_toggle_storm(1'b1);
        test_release();
        test_toggle_storm(1'b0);
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
